fp_addsub_seq: RTL
==================

Name: fp_addsub_seq

Overview:
- Parametrised sequential floating-point adder/subtractor: a single-module controller plus datapath, generalised in exponent and mantissa width.
- Adds an add/sub mode, early-exit alignment, zero/underflow/overflow handling and a busy/done handshake.
- Sits behind a requesting unit that issues one operation at a time and waits for done.
- Format: {sign, biased exponent EXP_W, fraction MAN_W}, hidden leading 1, no subnormals, truncation rounding.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 23, stored fraction width (>=2); internal magnitude is MAN_W+2 bits (carry + hidden + fraction).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset as already decided.
- start  in  1  request; accepted only when busy=0.
- op_sub  in  1  0: A+B, 1: A-B (B sign inverted at capture).
- a  in  1+EXP_W+MAN_W  operand A, sampled on accept edge only.
- b  in  1+EXP_W+MAN_W  operand B, sampled on accept edge only.
- result  out  1+EXP_W+MAN_W  registered result; held until the next accepted start.
- done  out  1  one-cycle pulse when result/flags become valid.
- busy  out  1  high from the cycle after accept through the done cycle.
- ovf  out  1  overflow/special flag for the last result.
- unf  out  1  underflow-flush flag for the last result.

Behaviour:
- Reset: state=IDLE; result=0, done=0, busy=0, ovf=0, unf=0; all internal registers cleared. Reset mid-operation aborts immediately, with no done pulse.
- States: IDLE, ALIGN, ADD, CARRY, NORM, FIN.
- IDLE: start=1 captures operands on that edge and goes to ALIGN. Capture also clears ovf/unf. start while busy is ignored.
- Operand decode: exp==0 means zero (magnitude 0, mantissa ignored). exp==all-ones means special.
- Special path: if A or B is special (A checked first), the ALIGN cycle loads result={that operand's captured sign, all-ones, 0}, sets ovf=1 and goes to FIN.
- ALIGN, one decision per cycle:
  - exponents equal, or either operand zero (zero takes the other's exponent): go to ADD.
  - difference > MAN_W+1: early exit. Smaller magnitude := 0, its exponent := larger exponent, go to ADD (1 cycle total).
  - otherwise: shift the smaller-exponent magnitude right 1 and increment its exponent; stay in ALIGN.
- ADD (1 cycle):
  - Same effective signs: sum, sign = A sign.
  - Different signs: larger magnitude minus smaller, sign of the larger.
  - Equal magnitudes: result +0.
  - Next state: CARRY if the sum's carry bit is set, else NORM.
- CARRY (1 cycle): shift right 1, exponent+1. If the exponent reaches all-ones: result={sign, all-ones, 0}, ovf=1, go to FIN. Otherwise go to NORM.
- NORM, per cycle:
  - magnitude==0: result=+0 (all bits 0), go to FIN.
  - hidden bit=1: pack {sign, exp, fraction}, go to FIN.
  - hidden bit=0, exp==1: flush result to +0, unf=1, go to FIN.
  - otherwise: shift left 1, exp-1; stay in NORM.
- FIN: done=1 for exactly this cycle, busy=1, result/flags already valid; next state IDLE. A start in FIN is ignored.
- busy=0 only in IDLE. Back-to-back: a start in the first IDLE cycle after FIN is accepted.
- Latency from accept edge to done:
  - special: 2 cycles.
  - normal: 1 + align steps (<=MAN_W+2) + 1 (ADD) + carry (0/1) + norm steps + 1.
- Width rules: fraction bits shifted out on the right are discarded (truncation). Exponent arithmetic is done in EXP_W+1 bits to detect wrap.

Test Plan:
- EXP_W=8, MAN_W=23: a=0x3F800000 (1.0), b=0x40000000 (2.0), op_sub=0 -> result=0x40400000, one done pulse, ovf=unf=0, latency 5 cycles (1 align, no carry, no norm shift).
- a=0x3F800000, b=0x40000000, op_sub=1 -> result=0xBF800000 (-1.0); a=0x40400000 minus itself -> result=0x00000000.
- a=0x3F800000, b=0x30800000 (2^-30), add -> early exit in one ALIGN cycle, result=0x3F800000.
- a=b=0x7F7FFFFF, add -> CARRY overflow, result=0x7F800000, ovf=1. a=0x7F800000, b=0x3F800000 -> result=0x7F800000, ovf=1, latency 2.
- a=0x00C00000, b=0x00800000, op_sub=1 -> normalisation underflow, result=0x00000000, unf=1.
- Assert rst while in ALIGN -> next cycle busy=0, done=0, result=0. start while busy -> ignored, with no second done. Rerun the first scenario with EXP_W=5, MAN_W=10 (half): 0x3C00+0x4000 -> 0x4200.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Sequential floating-point adder/subtractor, parametrised in exponent and fraction width.
// One operation at a time: align, add, carry fix-up, normalise, then a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accept edge
// ALIGN | special-operand check, then one exponent-alignment decision per cycle
// ADD   | signed-magnitude add/subtract of the aligned magnitudes
// CARRY | renormalise after a carry out of the hidden bit, overflow check
// NORM  | left-shift until the hidden bit is set, or flush to zero
// FIN   | result and flags valid, done pulse
module fp_addsub_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     op_sub,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic [EXP_W+MAN_W:0]     result,
   output logic                     done,
   output logic                     busy,
   output logic                     ovf,
   output logic                     unf
);

   localparam int W = 1 + EXP_W + MAN_W;
   localparam int M = MAN_W + 2;
   localparam int E = EXP_W + 1;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [E-1:0]     E_ONE    = E'(1);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, CARRY, NORM, FIN} state_t;

   state_t         state, state_n;
   logic           sa, sb, rs, spa, spb;
   logic           sa_n, sb_n, rs_n, spa_n, spb_n;
   logic [E-1:0]   ea, eb, re;
   logic [E-1:0]   ea_n, eb_n, re_n;
   logic [M-1:0]   ma, mb, rm;
   logic [M-1:0]   ma_n, mb_n, rm_n;
   logic [W-1:0]   result_n;
   logic           ovf_n, unf_n;

   logic [EXP_W-1:0] a_exp, b_exp;
   logic           ea_gt;
   logic [E-1:0]   diff;

   assign a_exp = a[W-2 -: EXP_W];
   assign b_exp = b[W-2 -: EXP_W];
   assign ea_gt = ea > eb;
   assign diff  = ea_gt ? (ea - eb) : (eb - ea);

   assign done = (state == FIN);
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sa     <= 1'b0;
         sb     <= 1'b0;
         rs     <= 1'b0;
         spa    <= 1'b0;
         spb    <= 1'b0;
         ea     <= '0;
         eb     <= '0;
         re     <= '0;
         ma     <= '0;
         mb     <= '0;
         rm     <= '0;
         result <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         state  <= state_n;
         sa     <= sa_n;
         sb     <= sb_n;
         rs     <= rs_n;
         spa    <= spa_n;
         spb    <= spb_n;
         ea     <= ea_n;
         eb     <= eb_n;
         re     <= re_n;
         ma     <= ma_n;
         mb     <= mb_n;
         rm     <= rm_n;
         result <= result_n;
         ovf    <= ovf_n;
         unf    <= unf_n;
      end
   end

   always_comb begin
      state_n  = state;
      sa_n     = sa;
      sb_n     = sb;
      rs_n     = rs;
      spa_n    = spa;
      spb_n    = spb;
      ea_n     = ea;
      eb_n     = eb;
      re_n     = re;
      ma_n     = ma;
      mb_n     = mb;
      rm_n     = rm;
      result_n = result;
      ovf_n    = ovf;
      unf_n    = unf;
      case (state)
         IDLE: begin
            if (start) begin
               sa_n    = a[W-1];
               sb_n    = b[W-1] ^ op_sub;
               ea_n    = {1'b0, a_exp};
               eb_n    = {1'b0, b_exp};
               ma_n    = (a_exp == '0) ? '0 : {2'b01, a[MAN_W-1:0]};
               mb_n    = (b_exp == '0) ? '0 : {2'b01, b[MAN_W-1:0]};
               spa_n   = (a_exp == EXP_ONES);
               spb_n   = (b_exp == EXP_ONES);
               ovf_n   = 1'b0;
               unf_n   = 1'b0;
               state_n = ALIGN;
            end
         end
         ALIGN: begin
            if (spa) begin
               result_n = {sa, EXP_ONES, {MAN_W{1'b0}}};
               ovf_n    = 1'b1;
               state_n  = FIN;
            end else if (spb) begin
               result_n = {sb, EXP_ONES, {MAN_W{1'b0}}};
               ovf_n    = 1'b1;
               state_n  = FIN;
            end else if (ea == eb || ma == '0 || mb == '0) begin
               if (ma == '0)
                  ea_n = eb;
               else if (mb == '0)
                  eb_n = ea;
               state_n = ADD;
            end else if (int'(diff) > MAN_W + 1) begin
               // Smaller operand would shift out entirely: skip the walk.
               if (ea_gt) begin
                  mb_n = '0;
                  eb_n = ea;
               end else begin
                  ma_n = '0;
                  ea_n = eb;
               end
               state_n = ADD;
            end else if (ea_gt) begin
               mb_n = mb >> 1;
               eb_n = eb + E_ONE;
            end else begin
               ma_n = ma >> 1;
               ea_n = ea + E_ONE;
            end
         end
         ADD: begin
            re_n = ea;
            if (sa == sb) begin
               rm_n = ma + mb;
               rs_n = sa;
            end else if (ma > mb) begin
               rm_n = ma - mb;
               rs_n = sa;
            end else if (mb > ma) begin
               rm_n = mb - ma;
               rs_n = sb;
            end else begin
               rm_n = '0;
               rs_n = 1'b0;
            end
            state_n = rm_n[M-1] ? CARRY : NORM;
         end
         CARRY: begin
            rm_n = rm >> 1;
            re_n = re + E_ONE;
            if (re_n[EXP_W] || re_n[EXP_W-1:0] == EXP_ONES) begin
               result_n = {rs, EXP_ONES, {MAN_W{1'b0}}};
               ovf_n    = 1'b1;
               state_n  = FIN;
            end else begin
               state_n = NORM;
            end
         end
         NORM: begin
            if (rm == '0) begin
               result_n = '0;
               state_n  = FIN;
            end else if (rm[MAN_W]) begin
               result_n = {rs, re[EXP_W-1:0], rm[MAN_W-1:0]};
               state_n  = FIN;
            end else if (re == E_ONE) begin
               result_n = '0;
               unf_n    = 1'b1;
               state_n  = FIN;
            end else begin
               rm_n = rm << 1;
               re_n = re - E_ONE;
            end
         end
         FIN: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule
